// File: rtl/cu_control_store.sv
// cu_control_store: writable microprogram control store.
// A byte-stream loader fills the store big-endian, one word per WORD_W/8
// accepted bytes; in RUN the word addressed by car_data is read combinationally.
// Outside RUN the store drives an all-zero word so the CAR holds.
module cu_control_store #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 24,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] car_data,
    input  logic              load_en,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              load_done,
    output logic              run,
    output logic [ADDR_W:0]   words_loaded,
    output logic [7:0]        ld_csum,
    output logic [WORD_W-1:0] control_word
);

    localparam int NBYTES = WORD_W / 8;
    localparam int PH_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NBYTES - 1);
    localparam logic [ADDR_W:0] WL_MAX  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [PH_W-1:0]     phase;
    logic [WORD_W-1:0]   part_word;
    logic [WORD_W-1:0]   assembled;
    logic                accept;
    logic                wr_en;
    logic [WORD_W-1:0]   mem [DEPTH];

    // Incoming byte lands in the low lane; earlier bytes shift toward the MSBs.
    assign assembled = (part_word << 8) | WORD_W'(ld_byte);
    assign accept    = ld_ready && ld_valid;
    assign wr_en     = accept && (phase == PH_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        next_state   = state;
        ld_ready     = 1'b0;
        run          = 1'b0;
        control_word = '0;
        case (state)
            IDLE: begin
                if (load_en) next_state = LOAD;
            end
            LOAD: begin
                ld_ready = load_en;
                if (!load_en) begin
                    next_state = (words_loaded != '0) ? RUN : IDLE;
                end
            end
            RUN: begin
                run          = 1'b1;
                control_word = mem[car_data];
                if (load_en) next_state = LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    // Loader datapath: pointer, byte phase, partial word, counters, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            phase        <= '0;
            part_word    <= '0;
            words_loaded <= '0;
            ld_csum      <= '0;
            load_done    <= 1'b0;
        end else begin
            load_done <= (state == LOAD) && !load_en && (words_loaded != '0);
            if ((state == IDLE || state == RUN) && load_en) begin
                wr_ptr       <= '0;
                phase        <= '0;
                words_loaded <= '0;
                ld_csum      <= '0;
            end else if (state == LOAD) begin
                if (!load_en) begin
                    // A partial word is dropped; the shift register needs no
                    // clearing since a full word shifts all stale bytes out.
                    phase <= '0;
                end else if (accept) begin
                    ld_csum   <= ld_csum ^ ld_byte;
                    part_word <= assembled;
                    if (phase == PH_LAST) begin
                        phase  <= '0;
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                        if (words_loaded != WL_MAX) begin
                            words_loaded <= words_loaded + (ADDR_W + 1)'(1);
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
            end
        end
    end

    // Store array write port; contents survive reset and reloads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= assembled;
        end
    end

endmodule

// File: tb/tb_cu_control_store.sv
// tb_cu_control_store: directed test of the microprogram control store.
// Stimulus pushes expected values into a queue; a monitor on the falling
// edge pops and compares them against the DUT outputs.
module tb_cu_control_store;

    localparam int K_CW    = 0;
    localparam int K_RUN   = 1;
    localparam int K_RDY   = 2;
    localparam int K_DONE  = 3;
    localparam int K_WL    = 4;
    localparam int K_CSUM  = 5;
    localparam int K_PULSE = 6;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  car_data;
    logic        load_en;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        load_done;
    logic        run;
    logic [8:0]  words_loaded;
    logic [7:0]  ld_csum;
    logic [23:0] control_word;

    chk_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   pulses = 0;

    cu_control_store #(.ADDR_W(8), .WORD_W(24), .DEPTH(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .car_data     (car_data),
        .load_en      (load_en),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .ld_ready     (ld_ready),
        .load_done    (load_done),
        .run          (run),
        .words_loaded (words_loaded),
        .ld_csum      (ld_csum),
        .control_word (control_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_CW:    return {8'h00, control_word};
            K_RUN:   return {31'd0, run};
            K_RDY:   return {31'd0, ld_ready};
            K_DONE:  return {31'd0, load_done};
            K_WL:    return {23'd0, words_loaded};
            K_CSUM:  return {24'd0, ld_csum};
            default: return pulses;
        endcase
    endfunction

    // Monitor: count load_done pulses, then check every queued expectation.
    always @(negedge clk) begin
        chk_t c;
        logic [31:0] a;
        if (load_done === 1'b1) pulses++;
        while (q.size() > 0) begin
            c = q.pop_front();
            a = actual(c.kind);
            total++;
            if (a !== c.exp) begin
                bad++;
                $display("FAIL %s: got %0h expected %0h", c.name, a, c.exp);
            end
        end
    end

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned n = 0;
        while (!ld_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL ld_ready_timeout: got 0 expected 1");
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        tick();
        ld_valid = 1'b0;
        ld_byte  = 8'h00;
        repeat (gap) tick();
    endtask

    task automatic read_word(input logic [7:0] addr, input logic [23:0] exp, input string name);
        car_data = addr;
        #1;
        expect_val(K_CW, {8'h00, exp}, name);
    endtask

    initial begin
        int unsigned w;
        rst_n    = 1'b0;
        car_data = 8'h00;
        load_en  = 1'b0;
        ld_valid = 1'b0;
        ld_byte  = 8'h00;

        // Reset state.
        repeat (2) tick();
        expect_val(K_CW, 0, "rst_cw");
        expect_val(K_RUN, 0, "rst_run");
        expect_val(K_RDY, 0, "rst_ready");
        expect_val(K_DONE, 0, "rst_done");
        expect_val(K_WL, 0, "rst_wl");
        expect_val(K_CSUM, 0, "rst_csum");
        tick();
        rst_n = 1'b1;

        // Idle with random addresses and a stray ld_valid: nothing happens.
        ld_valid = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            car_data = 8'($urandom);
            tick();
            expect_val(K_CW, 0, "idle_cw");
            expect_val(K_RUN, 0, "idle_run");
            expect_val(K_RDY, 0, "idle_ready");
        end
        ld_valid = 1'b0;
        expect_val(K_PULSE, 0, "idle_pulses");
        expect_val(K_WL, 0, "idle_wl");

        // Two-word load.
        load_en = 1'b1;
        tick();
        expect_val(K_RDY, 1, "load_ready");
        expect_val(K_CW, 0, "load_cw");
        send_byte(8'h00, 0); send_byte(8'hA0, 0); send_byte(8'h00, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
        load_en = 1'b0;
        tick();
        expect_val(K_RUN, 1, "l1_run");
        expect_val(K_DONE, 1, "l1_done");
        expect_val(K_WL, 2, "l1_wl");
        expect_val(K_CSUM, 32'hD0, "l1_csum");
        read_word(8'd0, 24'h00A000, "l1_mem0");
        tick();
        expect_val(K_DONE, 0, "l1_done_drop");
        read_word(8'd1, 24'h123456, "l1_mem1");
        tick();
        expect_val(K_PULSE, 1, "l1_pulses");

        // One word plus a trailing partial byte, with valid gaps.
        load_en = 1'b1;
        tick();
        expect_val(K_CW, 0, "l2_cw_in_load");
        expect_val(K_WL, 0, "l2_wl_clear");
        expect_val(K_CSUM, 0, "l2_csum_clear");
        send_byte(8'h11, 2); send_byte(8'h22, 0);
        send_byte(8'h33, 3); send_byte(8'h44, 1);
        load_en = 1'b0;
        tick();
        expect_val(K_WL, 1, "l2_wl");
        expect_val(K_CSUM, 32'h44, "l2_csum");
        expect_val(K_DONE, 1, "l2_done");
        read_word(8'd0, 24'h112233, "l2_mem0");
        tick();
        read_word(8'd1, 24'h123456, "l2_mem1_kept");
        expect_val(K_PULSE, 2, "l2_pulses");

        // Empty load from RUN returns to IDLE without load_done.
        load_en = 1'b1;
        repeat (3) tick();
        load_en = 1'b0;
        tick();
        expect_val(K_RUN, 0, "l3_run");
        expect_val(K_CW, 0, "l3_cw");
        expect_val(K_DONE, 0, "l3_done");
        expect_val(K_WL, 0, "l3_wl");
        tick();
        expect_val(K_PULSE, 2, "l3_pulses");

        // Short load to get back into RUN; mem[1] must survive.
        load_en = 1'b1;
        tick();
        send_byte(8'hAB, 0); send_byte(8'hCD, 0); send_byte(8'hEF, 0);
        load_en = 1'b0;
        tick();
        read_word(8'd0, 24'hABCDEF, "l4_mem0");
        tick();
        read_word(8'd1, 24'h123456, "l4_mem1_kept");

        // 257-word reload from RUN: wraps and saturates.
        load_en = 1'b1;
        tick();
        for (int unsigned i = 0; i < 257; i++) begin
            w = i;
            car_data = 8'($urandom);
            #1;
            expect_val(K_CW, 0, "l5_cw_in_load");
            expect_val(K_RUN, 0, "l5_run_in_load");
            send_byte(8'h00, 0);
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
        end
        load_en = 1'b0;
        tick();
        expect_val(K_WL, 32'h100, "l5_wl_sat");
        expect_val(K_CSUM, 32'h01, "l5_csum");
        expect_val(K_DONE, 1, "l5_done");
        read_word(8'd0, 24'h000100, "l5_mem0_wrap");
        tick();
        read_word(8'd255, 24'h0000FF, "l5_mem255");
        tick();
        read_word(8'd1, 24'h000001, "l5_mem1");
        tick();
        read_word(8'd128, 24'h000080, "l5_mem128");
        expect_val(K_PULSE, 4, "l5_pulses");

        // Reset in the middle of a word.
        load_en = 1'b1;
        tick();
        send_byte(8'h77, 0); send_byte(8'h88, 0);
        rst_n = 1'b0;
        #1;
        expect_val(K_RDY, 0, "mid_rst_ready");
        expect_val(K_RUN, 0, "mid_rst_run");
        expect_val(K_CW, 0, "mid_rst_cw");
        expect_val(K_WL, 0, "mid_rst_wl");
        expect_val(K_CSUM, 0, "mid_rst_csum");
        expect_val(K_DONE, 0, "mid_rst_done");
        load_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        expect_val(K_RUN, 0, "post_rst_run");
        expect_val(K_CW, 0, "post_rst_cw");
        load_en = 1'b1;
        tick();
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
        load_en = 1'b0;
        tick();
        expect_val(K_WL, 1, "l6_wl");
        expect_val(K_CSUM, 0, "l6_csum");
        read_word(8'd0, 24'h010203, "l6_mem0");
        tick();
        read_word(8'd1, 24'h000001, "l6_mem1_kept");
        expect_val(K_PULSE, 5, "l6_pulses");

        // Let the monitor drain the queue, bounded.
        for (int unsigned i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
